rc4_ksa_engine: RTL and testbench
=================================

# rc4_ksa_engine

Parametrised RC4 key-scheduling engine: optionally fills the S-box memory with the identity permutation, then runs the key-scheduling swap pass over a single-port synchronous RAM. Generalised in S-box depth and key length, with a selectable init pass and skipping of self-swaps (i == j). Sits between the key-search/decrypt controller (start/done handshake) and the S-box RAM (address/data/wren/q).

## Interface
Parameters:
- ADDR_W, 8: S-box address and data width; S-box depth N = 2^ADDR_W; legal 2..8.
- KEY_BYTES, 3: secret key length in bytes; legal 1..32.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; level, sampled only in IDLE and DONE.
- init_en  in  1  captured on start; 1 = run identity init pass first, 0 = use RAM contents as-is.
- secret_key  in  KEY_BYTES*8  key; byte 0 = secret_key[KEY_BYTES*8-1 -: 8] (MSB first); held stable while busy.
- ram_q  in  ADDR_W  RAM read data.
- ram_address  out  ADDR_W  registered RAM address.
- ram_data  out  ADDR_W  registered RAM write data.
- ram_wren  out  1  registered write enable, one-cycle pulses.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high in DONE.

## Operation
- States: IDLE, INIT, RD_I, WT_I, CAP_I, RD_J, WT_J, CAP_J, WR_J, WR_I, NEXT, DONE.
- IDLE: start=1 -> i=0, j=0, k=0, latch init_en; go INIT if init_en, else RD_I.
- INIT: each cycle ram_address=i, ram_data=i, ram_wren=1; i increments; after i = N-1 written, i=0 and go RD_I. Exactly N writes.
- RD_I: ram_address<=i. WT_I: wait. CAP_I: si<=ram_q; j<=j + ram_q + key_byte[k] (mod N; key byte truncated to low ADDR_W bits).
- RD_J: if j == i -> NEXT (no read, no write); else ram_address<=j. WT_J: wait. CAP_J: sj<=ram_q.
- WR_J: ram_address=j, ram_data=si, ram_wren=1. WR_I: ram_address=i, ram_data=sj, ram_wren=1.
- NEXT: if i == N-1 -> DONE; else i<=i+1, k<=(k == KEY_BYTES-1) ? 0 : k+1 (counter, no modulo divider), go RD_I.
- DONE: hold while start=1; start=0 -> IDLE. Restart requires start to drop then rise.
- start changes while busy are ignored; no abort other than reset_n.
- Sum j + S[i] + key computed at ADDR_W bits, wrap mod N.

## Timing
- Reset (reset_n=0, any state, immediate): state=IDLE, i=j=k=0, ram_address=0, ram_data=0, ram_wren=0, busy=0, done=0; si/sj=0.
- RAM contract: address registered by RAM at edge; ram_q valid the following cycle; engine samples ram_q two edges after driving ram_address (RD -> WT -> CAP).
- ram_wren is 0 in every state except INIT, WR_J, WR_I.
- start seen at edge t -> busy=1 from t+1.
- INIT: N cycles. Swap iteration: 9 cycles (RD_I..NEXT); self-swap iteration: 5 cycles (RD_I, WT_I, CAP_I, RD_J, NEXT).
- Total busy cycles = (init_en ? N : 0) + 9*(N - s) + 5*s, s = number of self-swap iterations.
- done rises the cycle after NEXT with i = N-1; falls the cycle after start sampled low.
- reset_n asserted mid-INIT or mid-swap: RAM left partially written; no further writes after reset edge.

## Test plan
- ADDR_W=2, KEY_BYTES=1, key=8'h00, init_en=1 -> RAM ends [0,2,3,1]; 8 writes total (4 init + 4 swap); iterations i=0,1 are self-swaps; busy exactly 4+5*2+9*2=32 cycles.
- ADDR_W=2, KEY_BYTES=2, key=16'h0102, init_en=1 -> swaps (0,1),(1,3), skip i=2, (3,0); RAM ends [0,3,2,1]; k sequence 0,1,0,1.
- ADDR_W=2, KEY_BYTES=1, key=0, init_en=0, RAM preloaded [0,1,2,3] -> same result as first case, zero INIT writes, busy 28 cycles.
- ADDR_W=8, KEY_BYTES=3, init_en=1, key=24'h000000 -> RAM matches software RC4 KSA model byte-for-byte; done holds while start=1, returns to IDLE one cycle after start=0; second start reruns correctly.
- reset_n pulsed low during WR_J of iteration 5 -> all outputs at reset values same cycle, no ram_wren afterwards, next start runs a full correct schedule.
- start toggled low/high while busy -> no effect on state sequence or final RAM contents.

Source files
------------

// File: rtl/rc4_ksa_engine.sv
// rc4_ksa_engine: RC4 key-scheduling engine (optional identity init + swap pass) over a single-port sync S-box RAM
// Ports: clk, reset_n (async active-low); start/init_en/secret_key from the controller, busy/done back to it;
// ram_address/ram_data/ram_wren (registered) to the S-box RAM, ram_q read data returned one cycle after the address is registered.
module rc4_ksa_engine #(
  parameter int ADDR_W    = 8,
  parameter int KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   init_en,
  input  logic [KEY_BYTES*8-1:0] secret_key,
  input  logic [ADDR_W-1:0]      ram_q,
  output logic [ADDR_W-1:0]      ram_address,
  output logic [ADDR_W-1:0]      ram_data,
  output logic                   ram_wren,
  output logic                   busy,
  output logic                   done
);
  localparam int KW = KEY_BYTES > 1 ? $clog2(KEY_BYTES) : 1;
  localparam logic [ADDR_W-1:0] LAST = '1;
  typedef enum logic [3:0] {IDLE, INIT, RD_I, WT_I, CAP_I, RD_J, WT_J, CAP_J, WR_J, WR_I, NEXT, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
  logic [ADDR_W-1:0] addr_q, addr_d, data_q, data_d;
  logic [KW-1:0] k_q, k_d;
  logic wren_q, wren_d;
  logic [ADDR_W-1:0] key_low;
  // key byte k, MSB-first, already truncated to the S-box width
  assign key_low = secret_key[8*(KEY_BYTES-1-int'(k_q)) +: ADDR_W];
  // RAM strobes are computed on the transition into a state so they are
  // presented during INIT, WR_J and WR_I themselves
  always_comb begin
    state_d = state_q;
    i_d = i_q;
    j_d = j_q;
    k_d = k_q;
    si_d = si_q;
    sj_d = sj_q;
    addr_d = addr_q;
    data_d = data_q;
    wren_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        i_d = '0;
        j_d = '0;
        k_d = '0;
        addr_d = '0;
        data_d = '0;
        wren_d = init_en;
        state_d = init_en ? INIT : RD_I;
      end
      INIT: begin
        i_d = i_q + ADDR_W'(1);
        addr_d = i_d;
        data_d = i_d;
        wren_d = i_q != LAST;
        state_d = i_q == LAST ? RD_I : INIT;
      end
      RD_I: begin
        addr_d = i_q;
        state_d = WT_I;
      end
      WT_I: state_d = CAP_I;
      CAP_I: begin
        si_d = ram_q;
        j_d = j_q + ram_q + key_low;
        state_d = RD_J;
      end
      RD_J: begin
        addr_d = j_q == i_q ? addr_q : j_q;
        state_d = j_q == i_q ? NEXT : WT_J;
      end
      WT_J: state_d = CAP_J;
      CAP_J: begin
        sj_d = ram_q;
        addr_d = j_q;
        data_d = si_q;
        wren_d = 1'b1;
        state_d = WR_J;
      end
      WR_J: begin
        addr_d = i_q;
        data_d = sj_q;
        wren_d = 1'b1;
        state_d = WR_I;
      end
      WR_I: state_d = NEXT;
      NEXT: if (i_q == LAST) state_d = DONE;
      else begin
        i_d = i_q + ADDR_W'(1);
        k_d = k_q == KW'(KEY_BYTES-1) ? '0 : k_q + KW'(1);
        state_d = RD_I;
      end
      DONE: state_d = start ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
      si_q <= '0;
      sj_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      wren_q <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q <= i_d;
      j_q <= j_d;
      k_q <= k_d;
      si_q <= si_d;
      sj_q <= sj_d;
      addr_q <= addr_d;
      data_q <= data_d;
      wren_q <= wren_d;
    end
  end
  assign ram_address = addr_q;
  assign ram_data = data_q;
  assign ram_wren = wren_q;
  assign busy = state_q != IDLE && state_q != DONE;
  assign done = state_q == DONE;
endmodule

// File: tb/tb_rc4_ksa_engine.sv
// tb_rc4_ksa_engine: vector table + write scoreboard for a 4-entry/2-byte-key and a 256-entry/3-byte-key engine
module tb_rc4_ksa_engine;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  logic start_a = 1'b0, init_a = 1'b0, pre_a = 1'b0;
  logic [15:0] key_a = '0;
  logic [1:0] q_a, addr_a, data_a;
  logic wren_a, busy_a, done_a;
  logic start_b = 1'b0, init_b = 1'b0;
  logic [23:0] key_b = '0;
  logic [7:0] q_b, addr_b, data_b;
  logic wren_b, busy_b, done_b;
  rc4_ksa_engine #(.ADDR_W(2), .KEY_BYTES(2)) u_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .init_en(init_a), .secret_key(key_a),
    .ram_q(q_a), .ram_address(addr_a), .ram_data(data_a), .ram_wren(wren_a), .busy(busy_a), .done(done_a));
  rc4_ksa_engine #(.ADDR_W(8), .KEY_BYTES(3)) u_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .init_en(init_b), .secret_key(key_b),
    .ram_q(q_b), .ram_address(addr_b), .ram_data(data_b), .ram_wren(wren_b), .busy(busy_b), .done(done_b));
  logic [1:0] mem_a [4];
  logic [7:0] mem_b [256];
  always @(posedge clk) begin
    if (pre_a) for (int x = 0; x < 4; x++) mem_a[x] <= 2'(x);
    else if (wren_a) mem_a[addr_a] <= data_a;
    q_a <= mem_a[addr_a];
  end
  always @(posedge clk) begin
    if (wren_b) mem_b[addr_b] <= data_b;
    q_b <= mem_b[addr_b];
  end
  bit sel = 1'b0;
  logic [7:0] m_addr, m_data;
  logic m_wren, m_busy, m_done, o_wren;
  always_comb begin
    m_addr = sel ? addr_b : {6'b0, addr_a};
    m_data = sel ? data_b : {6'b0, data_a};
    m_wren = sel ? wren_b : wren_a;
    m_busy = sel ? busy_b : busy_a;
    m_done = sel ? done_b : done_a;
    o_wren = sel ? wren_a : wren_b;
  end
  typedef struct packed {logic [7:0] a; logic [7:0] d;} wr_t;
  wr_t wq[$];
  wr_t e;
  int checks = 0, errors = 0;
  int sm [256];
  int exp_busy;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  // every write the engine makes is popped and compared against the model's write list
  always @(negedge clk) begin
    if (m_wren) begin
      if (!reset_n || wq.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        e = wq.pop_front();
        chk("wr_addr", int'(m_addr), int'(e.a));
        chk("wr_data", int'(m_data), int'(e.d));
      end
    end
    if (o_wren) chk("idle_inst_write", 1, 0);
  end
  // software RC4 KSA: pushes the expected write sequence and predicts busy cycles
  task automatic model(input bit s, input bit init, input logic [23:0] key);
    int n, kb, j, k, t, kbyte;
    n = s ? 256 : 4;
    kb = s ? 3 : 2;
    j = 0;
    k = 0;
    exp_busy = init ? n : 0;
    for (int i = 0; i < n; i++) begin
      if (init) begin
        sm[i] = i;
        wq.push_back({8'(i), 8'(i)});
      end else sm[i] = s ? int'(mem_b[i]) : int'(mem_a[i]);
    end
    for (int i = 0; i < n; i++) begin
      kbyte = int'((key >> (8*(kb-1-k))) & 24'hff);
      j = (j + sm[i] + kbyte % n) % n;
      if (j == i) exp_busy += 5;
      else begin
        exp_busy += 9;
        wq.push_back({8'(j), 8'(sm[i])});
        wq.push_back({8'(i), 8'(sm[j])});
        t = sm[i];
        sm[i] = sm[j];
        sm[j] = t;
      end
      k = (k + 1) % kb;
    end
  endtask
  task automatic set_start(input bit s, input logic v);
    if (s) start_b = v;
    else start_a = v;
  endtask
  task automatic run(input bit s, input bit init, input logic [23:0] key, input int glitch, output int bcyc);
    int cyc;
    sel = s;
    model(s, init, key);
    @(negedge clk);
    if (s) begin
      init_b = init;
      key_b = key;
    end else begin
      init_a = init;
      key_a = key[15:0];
    end
    set_start(s, 1'b1);
    bcyc = 0;
    cyc = 0;
    @(negedge clk);
    while (!m_done && cyc < 5000) begin
      if (m_busy) bcyc++;
      set_start(s, cyc < glitch ? 1'($urandom_range(0, 1)) : 1'b1);
      @(negedge clk);
      cyc++;
    end
    chk("done_timeout", int'(cyc < 5000), 1);
    chk("queue_empty", wq.size(), 0);
  endtask
  task automatic hold_release(input bit s);
    set_start(s, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("done_hold", int'(m_done), 1);
    end
    set_start(s, 1'b0);
    @(negedge clk);
    chk("done_fall", int'(m_done), 0);
    chk("idle_busy", int'(m_busy), 0);
  endtask
  task automatic check_big();
    int bad = 0;
    for (int x = 0; x < 256; x++) if (int'(mem_b[x]) != sm[x]) bad++;
    chk("big_ram_mismatches", bad, 0);
  endtask
  typedef struct {bit init; bit pre; logic [15:0] key; int busy; logic [7:0] ram; int glitch;} vec_t;
  initial begin
    vec_t tv[5];
    int bc, n, cyc;
    tv[0] = '{1'b1, 1'b0, 16'h0000, 32, 8'h2D, 0};
    tv[1] = '{1'b1, 1'b0, 16'h0102, 36, 8'h39, 0};
    tv[2] = '{1'b0, 1'b1, 16'h0000, 28, 8'h2D, 0};
    tv[3] = '{1'b1, 1'b0, 16'h0102, 36, 8'h39, 20};
    tv[4] = '{1'b0, 1'b0, 16'h0000, 32, 8'hE4, 0};
    repeat (2) @(negedge clk);
    chk("rst_addr", int'({addr_a, addr_b}), 0);
    chk("rst_data", int'({data_a, data_b}), 0);
    chk("rst_flags", int'({wren_a, busy_a, done_a, wren_b, busy_b, done_b}), 0);
    reset_n = 1'b1;
    for (int v = 0; v < 5; v++) begin
      if (tv[v].pre) begin
        @(negedge clk);
        pre_a = 1'b1;
        @(negedge clk);
        pre_a = 1'b0;
      end
      run(1'b0, tv[v].init, {8'h00, tv[v].key}, tv[v].glitch, bc);
      chk($sformatf("v%0d_busy", v), bc, tv[v].busy);
      chk($sformatf("v%0d_ram", v), int'({mem_a[0], mem_a[1], mem_a[2], mem_a[3]}), int'(tv[v].ram));
      hold_release(1'b0);
    end
    run(1'b1, 1'b1, 24'h000000, 0, bc);
    chk("big0_busy", bc, exp_busy);
    check_big();
    hold_release(1'b1);
    run(1'b1, 1'b1, 24'h0A1B2C, 0, bc);
    chk("big1_busy", bc, exp_busy);
    check_big();
    hold_release(1'b1);
    model(1'b1, 1'b1, 24'h000000);
    @(negedge clk);
    init_b = 1'b1;
    key_b = '0;
    start_b = 1'b1;
    n = 0;
    cyc = 0;
    while (n < 265 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (m_wren) n++;
    end
    chk("rst_reach_wr_j", n, 265);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_addr_data", int'({addr_b, data_b}), 0);
    chk("midrst_flags", int'({wren_b, busy_b, done_b}), 0);
    wq.delete();
    start_b = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_wren", int'(m_wren), 0);
    end
    reset_n = 1'b1;
    run(1'b1, 1'b1, 24'h000000, 0, bc);
    chk("after_rst_busy", bc, exp_busy);
    check_big();
    hold_release(1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end
endmodule
